multi_lane_fifo: RTL and testbench
==================================

# multi_lane_fifo

Parametrised successor of the team's width-converting FIFO. It buffers DATA_WIDTH-bit words in a circular store of 2**ADDR_WIDTH entries, with PAR_WRITE words accepted and PAR_READ words presented per transfer. New in this generation: asynchronous active-low reset, occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. It sits between lane-mismatched producer/consumer stages of the datapath.

## Interface
- DATA_WIDTH, 16: bits per word
- ADDR_WIDTH, 3: log2 of depth; DEPTH = 2**ADDR_WIDTH words
- PAR_WRITE, 1: words written per accepted write; 1 ≤ PAR_WRITE ≤ DEPTH
- PAR_READ, 1: words popped per accepted read; 1 ≤ PAR_READ ≤ DEPTH
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL
- clk  in  1  rising-edge clock; the block has one clock
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  synchronous clear of contents and error flags
- w_en  in  1  write request
- data_in  in  DATA_WIDTH*PAR_WRITE  write lanes; lane 0 = bits [DATA_WIDTH-1:0] = oldest word
- r_en  in  1  read request (pop)
- ready  out  1  count ≤ DEPTH-PAR_WRITE
- valid  out  1  count ≥ PAR_READ
- data_out  out  DATA_WIDTH*PAR_READ  show-ahead head words; lane 0 = oldest
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- overflow  out  1  sticky: w_en sampled while ready=0
- underflow  out  1  sticky: r_en sampled while valid=0

## Operation
- Write accepted (wr_acc) on a clock edge with w_en=1, ready=1, flush=0: lane i is stored at (wr_ptr+i) mod DEPTH for i=0..PAR_WRITE-1; wr_ptr advances by PAR_WRITE mod DEPTH.
- Read accepted (rd_acc) on a clock edge with r_en=1, valid=1, flush=0: rd_ptr advances by PAR_READ mod DEPTH. data_out lane j always shows the word at (rd_ptr+j) mod DEPTH; its contents are meaningful only while valid=1.
- Next count = count + PAR_WRITE·wr_acc − PAR_READ·rd_acc, evaluated with ADDR_WIDTH+2-bit signed intermediate arithmetic. Acceptance uses the pre-edge ready/valid values, so a simultaneous read does not free space for the same-cycle write.
- Rejected write: storage, wr_ptr, and count are unchanged, and overflow is set. Rejected read: nothing changes except that underflow is set.
- flush=1: wr_ptr, rd_ptr, count, overflow, and underflow are cleared and w_en/r_en are ignored that cycle. Memory contents are not cleared.
- Reset (rst_n=0, asynchronous): pointers, count, overflow, and underflow are cleared immediately. Outputs under reset are ready=1, valid=0, count=0, almost_full=(AF_LEVEL==0), almost_empty=1, overflow=0, underflow=0. data_out is undefined. A transfer in flight when reset asserts is discarded.
- Control is pointer/counter-based. The only state is wr_ptr, rd_ptr, count, and the two sticky flags.

## Timing
- Write-to-visibility latency: 1 cycle. After the edge that accepts a write, count, valid, and data_out reflect the new data.
- Every output is decoded from registers, with no combinational path from w_en, r_en, or data_in to any output.
- Flags update on the same edge as count.
- Reset release: the first edge with rst_n=1 may accept a transfer.
- Wrap-around: both pointers wrap modulo DEPTH. Multi-lane accesses split across the wrap boundary without a bubble.

## Structure
- Shared package holds DEPTH/COUNT_WIDTH derivation helpers (clog2) and the lane-indexing function (ptr+i) mod DEPTH.
- Sub-module `fifo_lane_ram`: a DEPTH×DATA_WIDTH register array with PAR_WRITE write ports and PAR_READ asynchronous read ports, indexed by base pointer plus lane. It has no reset.
- The top level holds the pointers, count, flags, and elaboration-time parameter checks (PAR_WRITE ≤ DEPTH, PAR_READ ≤ DEPTH, AF_LEVEL ≤ DEPTH).

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=3 (DEPTH 8), PAR_WRITE=2, PAR_READ=3, AF_LEVEL=6, AE_LEVEL=1.
- Reset: rst_n=0 asserted between edges → outputs change immediately to ready=1, valid=0, count=0, almost_empty=1, overflow=0, underflow=0.
- Ordering: write 0x0002_0001, then write 0x0004_0003 → count=4, valid=1, data_out=0x0003_0002_0001. Read → count=1, valid=0, lane 0 shows 0x0004.
- Full: four writes from empty → count=8, ready=0, almost_full=1. Fifth write → overflow=1, count stays 8, head unchanged.
- Simultaneous + wrap: starting at count=4 with rd_ptr=6, write and read on the same edge → count=3 and data_out order preserved across the 7→0 wrap. A write issued with ready=0 and r_en=1 on the same edge → only the read is accepted.
- Underflow: count=2, r_en=1 → underflow=1, count=2, rd_ptr unchanged.
- Flush/mid-op reset: flush at count=5 with w_en=1 → count=0, flags cleared, no write accepted. rst_n pulsed low between edges during a write burst → count=0 immediately, and the first post-release write lands at address 0.

Source files
------------

// File: rtl/multi_lane_fifo_pkg.sv
// Shared sizing helpers and lane addressing for the multi-lane FIFO.
package multi_lane_fifo_pkg;

   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   function automatic int unsigned count_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   function automatic int unsigned lane_idx(input int unsigned ptr, input int unsigned lane,
                                            input int unsigned depth);
      return (ptr + lane) % depth;
   endfunction

endpackage

// File: rtl/fifo_lane_ram.sv
// DEPTH x DATA_WIDTH register array with PAR_WRITE write lanes and PAR_READ async read lanes.
module fifo_lane_ram import multi_lane_fifo_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned PAR_WRITE  = 1,
   parameter int unsigned PAR_READ   = 1
) (
   input  logic                             i_clk,
   input  logic                             i_we,
   input  logic [ADDR_WIDTH-1:0]            i_wr_base,
   input  logic [DATA_WIDTH*PAR_WRITE-1:0]  i_wr_data,
   input  logic [ADDR_WIDTH-1:0]            i_rd_base,
   output logic [DATA_WIDTH*PAR_READ-1:0]   o_rd_data
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] w_wr_idx [PAR_WRITE];
   logic [ADDR_WIDTH-1:0] w_rd_idx [PAR_READ];

   for (genvar i = 0; i < PAR_WRITE; i++) begin : g_wr_idx
      assign w_wr_idx[i] = ADDR_WIDTH'(lane_idx(32'(i_wr_base), 32'(i), DEPTH));
   end

   for (genvar j = 0; j < PAR_READ; j++) begin : g_rd_lane
      assign w_rd_idx[j] = ADDR_WIDTH'(lane_idx(32'(i_rd_base), 32'(j), DEPTH));
      assign o_rd_data[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_rd_idx[j]];
   end

   // Lane addresses are distinct because PAR_WRITE <= DEPTH, so ports never collide.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int i = 0; i < int'(PAR_WRITE); i++) begin
            r_mem[w_wr_idx[i]] <= i_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/multi_lane_fifo.sv
// Circular multi-lane FIFO: pointer/count control, programmable flags, flush, sticky errors.
module multi_lane_fifo import multi_lane_fifo_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned PAR_WRITE  = 1,
   parameter int unsigned PAR_READ   = 1,
   parameter int unsigned AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 1,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            w_en,
   input  logic [DATA_WIDTH*PAR_WRITE-1:0] data_in,
   input  logic                            r_en,
   output logic                            ready,
   output logic                            valid,
   output logic [DATA_WIDTH*PAR_READ-1:0]  data_out,
   output logic [ADDR_WIDTH:0]             count,
   output logic                            almost_full,
   output logic                            almost_empty,
   output logic                            overflow,
   output logic                            underflow
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int unsigned CW    = count_width(ADDR_WIDTH);

   localparam logic [ADDR_WIDTH-1:0]        C_WR_STEP  = ADDR_WIDTH'(PAR_WRITE % DEPTH);
   localparam logic [ADDR_WIDTH-1:0]        C_RD_STEP  = ADDR_WIDTH'(PAR_READ % DEPTH);
   localparam logic signed [ADDR_WIDTH+1:0] C_WR_DELTA = (ADDR_WIDTH+2)'(PAR_WRITE);
   localparam logic signed [ADDR_WIDTH+1:0] C_RD_DELTA = (ADDR_WIDTH+2)'(PAR_READ);

   if (PAR_WRITE < 1 || PAR_WRITE > DEPTH) begin : g_chk_par_write
      $error("multi_lane_fifo: PAR_WRITE must be in 1..DEPTH");
   end
   if (PAR_READ < 1 || PAR_READ > DEPTH) begin : g_chk_par_read
      $error("multi_lane_fifo: PAR_READ must be in 1..DEPTH");
   end
   if (AF_LEVEL > DEPTH) begin : g_chk_af_level
      $error("multi_lane_fifo: AF_LEVEL must not exceed DEPTH");
   end

   logic [ADDR_WIDTH-1:0]        r_wr_ptr;
   logic [ADDR_WIDTH-1:0]        r_rd_ptr;
   logic [CW-1:0]                r_count;
   logic                         r_overflow;
   logic                         r_underflow;

   logic                         w_ready;
   logic                         w_valid;
   logic                         w_wr_acc;
   logic                         w_rd_acc;
   logic signed [ADDR_WIDTH+1:0] w_count_next;

   assign w_ready  = 32'(r_count) <= (DEPTH - PAR_WRITE);
   assign w_valid  = 32'(r_count) >= PAR_READ;
   assign w_wr_acc = w_en && w_ready && !flush;
   assign w_rd_acc = r_en && w_valid && !flush;

   // Acceptance uses pre-edge ready/valid, so a same-cycle read never frees room for the write.
   always_comb begin
      w_count_next = $signed({1'b0, r_count});
      if (w_wr_acc) w_count_next = w_count_next + C_WR_DELTA;
      if (w_rd_acc) w_count_next = w_count_next - C_RD_DELTA;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_WR_STEP;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_RD_STEP;
         r_count <= CW'(w_count_next);
         if (w_en && !w_ready) r_overflow <= 1'b1;
         if (r_en && !w_valid) r_underflow <= 1'b1;
      end
   end

   fifo_lane_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .PAR_WRITE  (PAR_WRITE),
      .PAR_READ   (PAR_READ)
   ) u_ram (
      .i_clk     (clk),
      .i_we      (w_wr_acc),
      .i_wr_base (r_wr_ptr),
      .i_wr_data (data_in),
      .i_rd_base (r_rd_ptr),
      .o_rd_data (data_out)
   );

   assign ready        = w_ready;
   assign valid        = w_valid;
   assign count        = r_count;
   assign almost_full  = 32'(r_count) >= AF_LEVEL;
   assign almost_empty = 32'(r_count) <= AE_LEVEL;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_multi_lane_fifo.sv
// Directed bench for multi_lane_fifo at DEPTH 8, 2 write lanes, 3 read lanes.
module tb_multi_lane_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        w_en;
   logic [31:0] data_in;
   logic        r_en;
   logic        ready;
   logic        valid;
   logic [47:0] data_out;
   logic [3:0]  count;
   logic        almost_full;
   logic        almost_empty;
   logic        overflow;
   logic        underflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_lane_fifo #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (3),
      .PAR_WRITE  (2),
      .PAR_READ   (3),
      .AF_LEVEL   (6),
      .AE_LEVEL   (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .w_en         (w_en),
      .data_in      (data_in),
      .r_en         (r_en),
      .ready        (ready),
      .valid        (valid),
      .data_out     (data_out),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit after the rising edge.
   task automatic cyc(input logic w, input logic r, input logic f, input logic [31:0] d);
      @(negedge clk);
      w_en    = w;
      r_en    = r;
      flush   = f;
      data_in = d;
      @(posedge clk);
      #1;
      w_en  = 1'b0;
      r_en  = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      w_en    = 1'b0;
      r_en    = 1'b0;
      data_in = '0;
      #1;
      chk("rst_count", 48'(count), 48'd0);
      chk("rst_ready", 48'(ready), 48'd1);
      chk("rst_valid", 48'(valid), 48'd0);
      chk("rst_ae", 48'(almost_empty), 48'd1);
      chk("rst_af", 48'(almost_full), 48'd0);
      chk("rst_flags", 48'({overflow, underflow}), 48'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ordering
      cyc(1'b1, 1'b0, 1'b0, 32'h0002_0001);
      chk("ord_cnt2", 48'(count), 48'd2);
      chk("ord_valid2", 48'(valid), 48'd0);
      chk("ord_ae2", 48'(almost_empty), 48'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0004_0003);
      chk("ord_cnt4", 48'(count), 48'd4);
      chk("ord_valid4", 48'(valid), 48'd1);
      chk("ord_data", data_out, 48'h0003_0002_0001);
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ord_rd_cnt", 48'(count), 48'd1);
      chk("ord_rd_valid", 48'(valid), 48'd0);
      chk("ord_rd_lane0", 48'(data_out[15:0]), 48'h0004);
      chk("ord_ae1", 48'(almost_empty), 48'd1);

      // Full and overflow
      cyc(1'b0, 1'b0, 1'b1, 32'h0);
      chk("fl_cnt0", 48'(count), 48'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0012_0011);
      cyc(1'b1, 1'b0, 1'b0, 32'h0014_0013);
      cyc(1'b1, 1'b0, 1'b0, 32'h0016_0015);
      chk("full_cnt6_ready", 48'({ready, almost_full}), 48'b11);
      cyc(1'b1, 1'b0, 1'b0, 32'h0018_0017);
      chk("full_cnt8", 48'(count), 48'd8);
      chk("full_ready", 48'(ready), 48'd0);
      chk("full_af", 48'(almost_full), 48'd1);
      cyc(1'b1, 1'b0, 1'b0, 32'h0099_0098);
      chk("ovf_flag", 48'(overflow), 48'd1);
      chk("ovf_cnt", 48'(count), 48'd8);
      chk("ovf_head", data_out, 48'h0013_0012_0011);

      // Flush, then build count=4 with rd_ptr=6
      cyc(1'b0, 1'b0, 1'b1, 32'h0);
      chk("fl_ovf_clr", 48'(overflow), 48'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0032_0031);
      cyc(1'b1, 1'b0, 1'b0, 32'h0034_0033);
      cyc(1'b1, 1'b0, 1'b0, 32'h0036_0035);
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_cnt0", 48'(count), 48'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0042_0041);
      cyc(1'b1, 1'b0, 1'b0, 32'h0044_0043);
      chk("wrap_cnt4", 48'(count), 48'd4);
      chk("wrap_data", data_out, 48'h0043_0042_0041);
      cyc(1'b1, 1'b1, 1'b0, 32'h0046_0045);
      chk("simul_cnt", 48'(count), 48'd3);
      chk("simul_data", data_out, 48'h0046_0045_0044);
      cyc(1'b1, 1'b0, 1'b0, 32'h0048_0047);
      cyc(1'b1, 1'b0, 1'b0, 32'h004A_0049);
      chk("cnt7_ready", 48'({count, ready}), 48'({4'd7, 1'b0}));
      cyc(1'b1, 1'b1, 1'b0, 32'h00AA_00A9);
      chk("rdonly_cnt", 48'(count), 48'd4);
      chk("rdonly_ovf", 48'(overflow), 48'd1);
      chk("rdonly_data", data_out, 48'h0049_0048_0047);

      // Underflow at count=2
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0052_0051);
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0054_0053);
      chk("unf_pre", 48'({count, underflow}), 48'({4'd2, 1'b0}));
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk("unf_flag", 48'(underflow), 48'd1);
      chk("unf_cnt", 48'(count), 48'd2);
      cyc(1'b1, 1'b0, 1'b0, 32'h0056_0055);
      chk("unf_rdptr", data_out, 48'h0055_0054_0053);

      // Flush at count=5 with w_en/r_en active
      cyc(1'b1, 1'b0, 1'b0, 32'h0058_0057);
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h005A_0059);
      chk("pfl_cnt5", 48'(count), 48'd5);
      cyc(1'b1, 1'b1, 1'b1, 32'hBEEF_BEEF);
      chk("flush_cnt", 48'(count), 48'd0);
      chk("flush_flags", 48'({overflow, underflow, valid}), 48'd0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0062_0061);
      cyc(1'b1, 1'b0, 1'b0, 32'h0064_0063);
      chk("pflush_data", data_out, 48'h0063_0062_0061);

      // Reset pulse between edges during a write burst
      cyc(1'b1, 1'b0, 1'b0, 32'h0072_0071);
      chk("burst_cnt6", 48'(count), 48'd6);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_cnt", 48'(count), 48'd0);
      chk("mrst_rdy_vld", 48'({ready, valid, almost_empty}), 48'b101);
      @(negedge clk);
      rst_n   = 1'b1;
      w_en    = 1'b1;
      data_in = 32'h0082_0081;
      @(posedge clk);
      #1;
      w_en = 1'b0;
      chk("mrst_first_wr", 48'(count), 48'd2);
      cyc(1'b1, 1'b0, 1'b0, 32'h0084_0083);
      chk("mrst_addr0", data_out, 48'h0083_0082_0081);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
